// File: rtl/dmem_arbiter.sv
// Two-requester arbiter and single-access sequencer in front of the data memory.
// Runs one access at a time through IDLE -> ACCESS -> DONE, and every output is registered.
module dmem_arbiter #(
   parameter int unsigned DEPTH = 1024,
   parameter bit          RR_EN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req,
   input  logic [1:0]  we,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic [1:0]  ack,
   output logic        err,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        mem_write,
   output logic        mem_read,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StAccess = 2'd1;
   localparam logic [1:0] StDone   = 2'd2;

   logic [1:0]  state;
   logic        last_grant;
   logic        gnt_q;
   logic        we_q;
   logic        bad_q;

   logic        gnt;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic        sel_bad;

   // A tie alternates only in round-robin mode; otherwise requester 0 wins whenever it asks.
   always_comb begin
      gnt = 1'b0;
      if (RR_EN && (req == 2'b11)) begin
         gnt = ~last_grant;
      end else if (req[0]) begin
         gnt = 1'b0;
      end else begin
         gnt = 1'b1;
      end
      sel_we    = gnt ? we[1]  : we[0];
      sel_addr  = gnt ? addr1  : addr0;
      sel_wdata = gnt ? wdata1 : wdata0;
      sel_bad   = (sel_addr[1:0] != 2'b00) || ({2'b00, sel_addr[31:2]} >= DEPTH);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= StIdle;
         last_grant <= 1'b1;
         gnt_q      <= 1'b0;
         we_q       <= 1'b0;
         bad_q      <= 1'b0;
         ack        <= 2'b00;
         err        <= 1'b0;
         rdata      <= 32'h0;
         busy       <= 1'b0;
         mem_write  <= 1'b0;
         mem_read   <= 1'b0;
         mem_addr   <= 32'h0;
         mem_wdata  <= 32'h0;
      end else begin
         case (state)
            StIdle: begin
               if (req != 2'b00) begin
                  state      <= StAccess;
                  gnt_q      <= gnt;
                  last_grant <= gnt;
                  we_q       <= sel_we;
                  bad_q      <= sel_bad;
                  busy       <= 1'b1;
                  // Rejected accesses never touch the memory bus.
                  mem_write  <= !sel_bad && sel_we;
                  mem_read   <= !sel_bad && !sel_we;
                  mem_addr   <= sel_bad ? 32'h0 : sel_addr;
                  mem_wdata  <= sel_bad ? 32'h0 : sel_wdata;
               end
            end
            StAccess: begin
               state     <= StDone;
               mem_write <= 1'b0;
               mem_read  <= 1'b0;
               mem_addr  <= 32'h0;
               mem_wdata <= 32'h0;
               ack       <= gnt_q ? 2'b10 : 2'b01;
               err       <= bad_q;
               rdata     <= (!bad_q && !we_q) ? mem_rdata : 32'h0;
            end
            StDone: begin
               state <= StIdle;
               ack   <= 2'b00;
               err   <= 1'b0;
               rdata <= 32'h0;
               busy  <= 1'b0;
            end
            default: begin
               state     <= StIdle;
               ack       <= 2'b00;
               err       <= 1'b0;
               rdata     <= 32'h0;
               busy      <= 1'b0;
               mem_write <= 1'b0;
               mem_read  <= 1'b0;
               mem_addr  <= 32'h0;
               mem_wdata <= 32'h0;
            end
         endcase
      end
   end

endmodule
